// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sweep states, default widths, latency bounds and parity helper (RAM_PARITY_EN)
package ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   localparam int DEF_DATA_W  = 20;
   localparam int DEF_ADDR_W  = 10;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;

   // Extra stored bit per word: one parity bit when RAM_PARITY_EN is defined
`ifdef RAM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   // Parity helper takes a zero-extended word; zero padding does not change the XOR
   localparam int PAR_MAX_W = 64;

   // Even parity: data XOR parity bit is always zero for a clean word
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - bare storage array, one write port, one synchronous read port, INIT-loaded (parity column with RAM_PARITY_EN)
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [(1<<ADDR_W)*DATA_W-1:0] INIT = '0
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [DATA_W+PAR_W-1:0]   wdata,
   input  logic                      re,
   input  logic [ADDR_W-1:0]         raddr,
   output logic [DATA_W+PAR_W-1:0]   rdata
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int WORD_W = DATA_W + PAR_W;

   typedef logic [DEPTH-1:0][WORD_W-1:0] mem_t;

   // Unpack INIT (word 0 in the top bits) into the array image, adding parity when present
   function automatic mem_t init_mem();
      mem_t                    m;
      logic [DEPTH*DATA_W-1:0] rest;
      logic [DATA_W-1:0]       d;
      m    = '0;
      rest = INIT;
      for (int i = 0; i < DEPTH; i++) begin
         d    = rest[DEPTH*DATA_W-1 -: DATA_W];
         rest = rest << DATA_W;
`ifdef RAM_PARITY_EN
         m[ADDR_W'(i)] = {even_parity(PAR_MAX_W'(d)), d};
`else
         m[ADDR_W'(i)] = d;
`endif
      end
      return m;
   endfunction

   mem_t              mem = init_mem();
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] rdata_d;

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port keeps its last word unless a read is requested (reads the pre-write contents)
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   // Read data register
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_pipe.sv
// rtl/ram_pipe.sv - single-port RAM with read pipeline, rvalid strobe and clear sweep; RAM_PARITY_EN adds parity and perr
module ram_pipe
   import ram_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LATENCY = 1,
   parameter logic [(1<<ADDR_W)*DATA_W-1:0] INIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write,
   input  logic              str,
   input  logic              ld,
   input  logic              clr,
   output logic [DATA_W-1:0] read,
   output logic              rvalid,
   output logic              busy
`ifdef RAM_PARITY_EN
   ,
   output logic              perr
`endif
);

   localparam int WORD_W = DATA_W + PAR_W;

   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("ram_pipe: LATENCY must be within 1..4");
   end

   // Stored word for a data value: data plus its parity bit when present
   function automatic logic [WORD_W-1:0] make_word(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
      return {even_parity(PAR_MAX_W'(d)), d};
`else
      return d;
`endif
   endfunction

   clr_state_e                state_q, state_d;
   logic [ADDR_W-1:0]         ptr_q, ptr_d;
   logic                      acc_st, acc_ld;
   logic                      arr_we;
   logic [ADDR_W-1:0]         arr_waddr;
   logic [WORD_W-1:0]         arr_wdata, arr_rdata;
   logic                      v1_q, v1_d, fwd_q, fwd_d;
   logic [WORD_W-1:0]         fwd_word_q, fwd_word_d;
   logic [WORD_W-1:0]         s1_word, last_word, out_word, hold_q, hold_d;
   logic [LATENCY-1:0]        pv_q, pv_d;
   logic [LATENCY*WORD_W-1:0] pw_q, pw_d;
   logic                      last_valid;

   // clr wins over requests in its own cycle; nothing is accepted during the sweep
   assign busy   = (state_q == CLEAR);
   assign acc_st = str && !busy && !clr;
   assign acc_ld = ld  && !busy && !clr;

   // Clear sequencer: next state and sweep pointer
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Array write port: the sweep owns it while busy, otherwise accepted stores
   always_comb begin
      arr_we    = acc_st;
      arr_waddr = addr;
      arr_wdata = make_word(write);
      if (busy) begin
         arr_we    = 1'b1;
         arr_waddr = ptr_q;
         arr_wdata = '0;
      end
   end

   // Stage-1 capture: load valid plus write-first forwarding of a same-cycle store
   always_comb begin
      v1_d       = acc_ld;
      fwd_d      = acc_ld && acc_st;
      fwd_word_d = make_word(write);
   end

   assign s1_word = fwd_q ? fwd_word_q : arr_rdata;

   // Read pipeline: shift valid and word by one stage per cycle
   always_comb begin
      pv_d               = pv_q << 1;
      pv_d[0]            = v1_q;
      pw_d               = pw_q << WORD_W;
      pw_d[WORD_W-1:0]   = s1_word;
   end

   assign last_valid = pv_q[LATENCY-1];
   assign last_word  = pw_q[LATENCY*WORD_W-1 -: WORD_W];
   assign out_word   = last_valid ? last_word : hold_q;

   // Result hold: the output keeps the last delivered word
   always_comb begin
      hold_d = out_word;
   end

   // All control and pipeline registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         v1_q       <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_word_q <= '0;
         pv_q       <= '0;
         pw_q       <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         v1_q       <= v1_d;
         fwd_q      <= fwd_d;
         fwd_word_q <= fwd_word_d;
         pv_q       <= pv_d;
         pw_q       <= pw_d;
         hold_q     <= hold_d;
      end
   end

   assign rvalid = last_valid;
   assign read   = out_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
   assign perr   = ^out_word;
`endif

   ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .INIT   (INIT)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (acc_ld),
      .raddr (addr),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_ram_pipe.sv
// tb/tb_ram_pipe.sv - directed bench for ram_pipe, LATENCY 1 and 3 instances sharing stimulus (RAM_PARITY_EN adds perr tests)
module tb_ram_pipe;

   localparam logic [16*20-1:0] INIT_V = {20'hABCDE, 300'd0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  addr = '0;
   logic [19:0] wdata = '0;
   logic        str = 1'b0, ld = 1'b0, clr = 1'b0;
   logic [19:0] read_a, read_b;
   logic        rvalid_a, rvalid_b, busy_a, busy_b;
`ifdef RAM_PARITY_EN
   logic        perr_a, perr_b;
`endif
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_pipe #(.DATA_W(20), .ADDR_W(4), .LATENCY(1), .INIT(INIT_V)) dut_a (
      .clk(clk), .rst(rst), .addr(addr), .write(wdata), .str(str), .ld(ld), .clr(clr),
      .read(read_a), .rvalid(rvalid_a), .busy(busy_a)
`ifdef RAM_PARITY_EN
      , .perr(perr_a)
`endif
   );

   ram_pipe #(.DATA_W(20), .ADDR_W(4), .LATENCY(3), .INIT(INIT_V)) dut_b (
      .clk(clk), .rst(rst), .addr(addr), .write(wdata), .str(str), .ld(ld), .clr(clr),
      .read(read_b), .rvalid(rvalid_b), .busy(busy_b)
`ifdef RAM_PARITY_EN
      , .perr(perr_b)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_cmp++; if (read_a !== 20'd0)  begin n_err++; $display("FAIL reset_read_a: got %h want 0", read_a); end
      n_cmp++; if (rvalid_a !== 1'b0) begin n_err++; $display("FAIL reset_rvalid_a: got %b want 0", rvalid_a); end
      n_cmp++; if (busy_a !== 1'b0)   begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
      n_cmp++; if (read_b !== 20'd0)  begin n_err++; $display("FAIL reset_read_b: got %h want 0", read_b); end
      n_cmp++; if (rvalid_b !== 1'b0) begin n_err++; $display("FAIL reset_rvalid_b: got %b want 0", rvalid_b); end
      n_cmp++; if (busy_b !== 1'b0)   begin n_err++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
`ifdef RAM_PARITY_EN
      n_cmp++; if (perr_a !== 1'b0)   begin n_err++; $display("FAIL reset_perr_a: got %b want 0", perr_a); end
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_init();
      ld = 1'b1; addr = 4'd0; tick();
      n_cmp++; if (rvalid_a !== 1'b0) begin n_err++; $display("FAIL init_early_rvalid: got %b want 0", rvalid_a); end
      ld = 1'b0; tick();
      n_cmp++; if (rvalid_a !== 1'b1)      begin n_err++; $display("FAIL init_rvalid0: got %b want 1", rvalid_a); end
      n_cmp++; if (read_a !== 20'hABCDE)   begin n_err++; $display("FAIL init_word0: got %h want abcde", read_a); end
      tick();
      n_cmp++; if (rvalid_a !== 1'b0)      begin n_err++; $display("FAIL init_strobe_len: got %b want 0", rvalid_a); end
      n_cmp++; if (read_a !== 20'hABCDE)   begin n_err++; $display("FAIL init_hold: got %h want abcde", read_a); end
      ld = 1'b1; addr = 4'd5; tick(); ld = 1'b0;
      n_cmp++; if (rvalid_b !== 1'b1 || read_b !== 20'hABCDE) begin n_err++; $display("FAIL init_b_word0: got %b/%h want 1/abcde", rvalid_b, read_b); end
      tick();
      n_cmp++; if (rvalid_a !== 1'b1 || read_a !== 20'd0) begin n_err++; $display("FAIL init_word5: got %b/%h want 1/0", rvalid_a, read_a); end
      tick(); tick();
      n_cmp++; if (rvalid_b !== 1'b1 || read_b !== 20'd0) begin n_err++; $display("FAIL init_b_word5: got %b/%h want 1/0", rvalid_b, read_b); end
   endtask

   task automatic test_write_first();
      str = 1'b1; ld = 1'b1; addr = 4'd1; wdata = 20'd202; tick();
      str = 1'b0; addr = 4'd2; tick();
      n_cmp++; if (rvalid_a !== 1'b1 || read_a !== 20'd202) begin n_err++; $display("FAIL wf_forward: got %b/%0d want 1/202", rvalid_a, read_a); end
      ld = 1'b0; str = 1'b1; wdata = 20'd303; tick();
      n_cmp++; if (rvalid_a !== 1'b1 || read_a !== 20'd0) begin n_err++; $display("FAIL wf_next_load: got %b/%0d want 1/0", rvalid_a, read_a); end
      addr = 4'd3; wdata = 20'd404; tick();
      n_cmp++; if (rvalid_b !== 1'b1 || read_b !== 20'd202) begin n_err++; $display("FAIL wf_forward_b: got %b/%0d want 1/202", rvalid_b, read_b); end
      n_cmp++; if (rvalid_a !== 1'b0 || read_a !== 20'd0) begin n_err++; $display("FAIL wf_hold_a: got %b/%0d want 0/0", rvalid_a, read_a); end
      str = 1'b0; tick(); tick();
   endtask

   task automatic test_back_to_back();
      int exp_va [7] = '{0, 1, 1, 1, 0, 0, 0};
      int exp_ra [7] = '{0, 202, 303, 404, 404, 404, 404};
      int exp_vb [7] = '{0, 0, 0, 1, 1, 1, 0};
      int exp_rb [7] = '{0, 0, 0, 202, 303, 404, 404};
      for (int i = 0; i < 7; i++) begin
         ld = (i < 3); addr = 4'(i + 1); tick();
         n_cmp++; if (rvalid_a !== 1'(exp_va[i]) || read_a !== 20'(exp_ra[i])) begin n_err++; $display("FAIL b2b_a[%0d]: got %b/%0d want %0d/%0d", i, rvalid_a, read_a, exp_va[i], exp_ra[i]); end
         n_cmp++; if (rvalid_b !== 1'(exp_vb[i]) || read_b !== 20'(exp_rb[i])) begin n_err++; $display("FAIL b2b_b[%0d]: got %b/%0d want %0d/%0d", i, rvalid_b, read_b, exp_vb[i], exp_rb[i]); end
      end
      ld = 1'b0;
   endtask

   task automatic test_clear();
      int cnt_a = 0, cnt_b = 0, first_low = -1;
      bit saw_rv = 1'b0;
      clr = 1'b1; ld = 1'b1; addr = 4'd4; tick();
      for (int k = 0; k < 20; k++) begin
         if (busy_a) cnt_a++;
         if (busy_b) cnt_b++;
         if (!busy_a && first_low < 0) first_low = k;
         if ((k <= 17 && rvalid_a) || rvalid_b) saw_rv = 1'b1;
         if (k == 18) begin
            n_cmp++; if (rvalid_a !== 1'b1 || read_a !== 20'd0) begin n_err++; $display("FAIL clr_first_accept: got %b/%h want 1/0", rvalid_a, read_a); end
         end
         clr   = (k == 5);
         str   = (k == 3);
         wdata = 20'd505;
         ld    = (k >= 3 && k <= 16);
         addr  = (k == 16) ? 4'd0 : 4'd4;
         tick();
      end
      n_cmp++; if (cnt_a != 16)     begin n_err++; $display("FAIL clr_busy_len_a: got %0d want 16", cnt_a); end
      n_cmp++; if (cnt_b != 16)     begin n_err++; $display("FAIL clr_busy_len_b: got %0d want 16", cnt_b); end
      n_cmp++; if (first_low != 16) begin n_err++; $display("FAIL clr_busy_fall: got %0d want 16", first_low); end
      n_cmp++; if (saw_rv !== 1'b0) begin n_err++; $display("FAIL clr_dropped_loads: got %b want 0", saw_rv); end
      for (int i = 0; i < 17; i++) begin
         ld = (i < 16); addr = 4'(i); tick();
         if (i >= 1) begin
            n_cmp++; if (rvalid_a !== 1'b1 || read_a !== 20'd0) begin n_err++; $display("FAIL clr_zero[%0d]: got %b/%h want 1/0", i - 1, rvalid_a, read_a); end
         end
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid_sweep();
      for (int i = 0; i < 16; i++) begin
         str = 1'b1; addr = 4'(i); wdata = 20'(100 + i); tick();
      end
      str = 1'b0; ld = 1'b1; addr = 4'd9; tick(); ld = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      repeat (7) tick();
      n_cmp++; if (busy_a !== 1'b1 || read_a !== 20'd109) begin n_err++; $display("FAIL mid_pre_a: got %b/%0d want 1/109", busy_a, read_a); end
      n_cmp++; if (read_b !== 20'd109) begin n_err++; $display("FAIL mid_pre_b: got %0d want 109", read_b); end
      #2; rst = 1'b1; #1;
      n_cmp++; if (busy_a !== 1'b0 || rvalid_a !== 1'b0 || read_a !== 20'd0) begin n_err++; $display("FAIL async_rst_a: got %b/%b/%h want 0/0/0", busy_a, rvalid_a, read_a); end
      n_cmp++; if (busy_b !== 1'b0 || rvalid_b !== 1'b0 || read_b !== 20'd0) begin n_err++; $display("FAIL async_rst_b: got %b/%b/%h want 0/0/0", busy_b, rvalid_b, read_b); end
      #2; rst = 1'b0;
      tick();
      for (int i = 0; i < 17; i++) begin
         ld = (i < 16); addr = 4'(i); tick();
         if (i >= 1) begin
            n_cmp++; if (rvalid_a !== 1'b1 || read_a !== ((i - 1 < 7) ? 20'd0 : 20'(100 + i - 1))) begin n_err++; $display("FAIL mid_contents[%0d]: got %b/%0d want 1/%0d", i - 1, rvalid_a, read_a, (i - 1 < 7) ? 0 : 100 + i - 1); end
         end
      end
      tick(); tick(); tick();
   endtask

`ifdef RAM_PARITY_EN
   task automatic test_parity();
      dut_a.u_array.mem[3][0] = ~dut_a.u_array.mem[3][0];
      ld = 1'b1; addr = 4'd3; tick();
      addr = 4'd9; tick();
      n_cmp++; if (rvalid_a !== 1'b1 || perr_a !== 1'b1 || read_a !== 20'd1) begin n_err++; $display("FAIL parity_bad: got %b/%b/%h want 1/1/1", rvalid_a, perr_a, read_a); end
      ld = 1'b0; tick();
      n_cmp++; if (rvalid_a !== 1'b1 || perr_a !== 1'b0 || read_a !== 20'd109) begin n_err++; $display("FAIL parity_clean: got %b/%b/%0d want 1/0/109", rvalid_a, perr_a, read_a); end
      tick();
      n_cmp++; if (rvalid_a !== 1'b0 || perr_a !== 1'b0) begin n_err++; $display("FAIL parity_hold: got %b/%b want 0/0", rvalid_a, perr_a); end
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_init();
      test_write_first();
      test_back_to_back();
      test_clear();
      test_reset_mid_sweep();
`ifdef RAM_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_pipe.md
# ram_pipe

- Parametrised, single-port, single-clock synchronous RAM with a configurable read pipeline, read-valid strobe and a built-in memory-clear sequencer.
- Successor to the fixed 1024×20 data memory, which it replaces in the CPU memory subsystem.
- Consumers must track `rvalid` rather than assume a fixed one-cycle read.

## Interface
- `DATA_W`, 20: word width in bits.
- `ADDR_W`, 10: address width; depth is `DEPTH = 1 << ADDR_W` (derived, not overridable).
- `LATENCY`, 1: read latency in cycles; legal range 1..4. Any other value is an elaboration error.
- `INIT`, all zeros: initial contents, `DEPTH*DATA_W` bits.
  - Word 0 occupies the most-significant `DATA_W` bits; word `DEPTH-1` occupies the least-significant.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `addr` in `ADDR_W`: word address for `str`/`ld`.
- `write` in `DATA_W`: store data.
- `str` in 1: store request.
- `ld` in 1: load request.
- `clr` in 1: start the clear sweep.
- `read` out `DATA_W`: load data.
- `rvalid` out 1: one-cycle strobe; `read` holds a new result.
- `busy` out 1: clear sweep in progress.
- `perr` out 1: parity error on the current result; only present with `RAM_PARITY_EN`.

## Operation
- A request is accepted at a rising edge when `busy=0`. While `busy=1`, `str` and `ld` are ignored and dropped; they are not queued.
- **Store:** `mem[addr] <= write` at the accepting edge.
- **Load:** `mem[addr]` is sampled at the accepting edge and carried through `LATENCY` pipeline stages.
- **`str` and `ld` together, same address:** write-first. The load returns the new `write` value.
- **Read hold:** `read` holds the last result until the next `rvalid`. It never returns to 0 except on reset.
- **Clear FSM states:** `IDLE`, `CLEAR`.
  - `IDLE` → `CLEAR` when `clr=1` at an edge. `clr` has priority over `str`/`ld` in that cycle; those requests are dropped.
  - In `CLEAR`, an internal counter `ptr` starts at 0 and writes 0 to `mem[ptr]` once per cycle.
  - After writing `DEPTH-1`, `ptr` wraps to 0 and the FSM returns to `IDLE`.
  - `clr` asserted while in `CLEAR` is ignored.
- **Loads in flight** when the sweep starts still complete with the data sampled at acceptance.
- **Reset behaviour:**
  - Clears the pipeline, `ptr` and the FSM, returning it to `IDLE`.
  - Does not touch array contents. `INIT` is applied only at time zero.
  - Reset during `CLEAR` aborts the sweep, leaving memory partially cleared.
- Out-of-range addresses cannot occur, because depth is a power of two.

## Timing
- **Reset values:** `read=0`, `rvalid=0`, `busy=0`, `perr=0`.
- **Load latency:** a load accepted at edge N gives `rvalid=1` and valid `read` after edge N+`LATENCY`, for exactly one cycle.
- **Throughput:** back-to-back loads give back-to-back `rvalid`.
- **Store visibility:** a store at edge N is visible to a load accepted at edge N (write-first) or later.
- **Clear timing:**
  - `clr` at edge N raises `busy` after edge N.
  - `busy` stays high for exactly `DEPTH` cycles.
  - The first accepted request after the sweep is at edge N+`DEPTH`+1.

## Configuration
- **`RAM_PARITY_EN` defined:**
  - Each word stores an extra even-parity bit computed from `write`. The clear sweep stores parity 0.
  - The parity bit is pipelined with the data.
  - `perr` rises with `rvalid` when the recomputed parity mismatches. `perr` has the same hold/reset behaviour as `read`.
  - `INIT` words get parity computed at time zero.
- **`RAM_PARITY_EN` undefined:** no parity storage and no `perr` port; the array is exactly `DATA_W` wide.

## Structure
- Shared package `ram_pkg`:
  - FSM state encoding (`IDLE`, `CLEAR`).
  - Default widths (20/10).
  - `LATENCY` bounds.
  - Parity function.
- One sub-module, `ram_array`: the bare storage array. It has one write port and one synchronous read port, and is `INIT`-loaded.
- `ram_pipe` holds the FSM, forwarding, pipeline and parity check.

## Test plan
- **INIT word 0 and time-zero contents:** `INIT` word 0 = 20'hABCDE, `LATENCY=1`, load addr 0 → `read=20'hABCDE` with `rvalid` one cycle later; load addr 5 → 0.
- **Write-first and subsequent load:** `str` addr 1 = 202 with `ld` addr 1 same cycle → `read=202` on the next `rvalid`; then load addr 2 → 0.
- **Pipelined latency:** `LATENCY=3`, loads to addr 1, 2, 3 on consecutive cycles (pre-stored 202/303/404) → three consecutive `rvalid` pulses 3 cycles after each request, data in order.
- **Clear sweep, `DEPTH=16`:** `clr` → `busy` high for 16 cycles; `str` addr 4 = 505 issued mid-sweep is dropped; loads after the sweep return 0 everywhere.
- **Reset mid-sweep and async reset:** `rst` during `CLEAR` at `ptr=7` → `busy=0`, `rvalid=0`, `read=0` immediately without a clock edge; addr 0–6 read 0 and addr 8+ keep old values.
- **Parity error (`RAM_PARITY_EN`):** force-flip one stored bit at addr 3, load addr 3 → `perr=1` coincident with `rvalid`; clean address → `perr=0`.
